// File: rtl/alu_pkg.sv
// Shared opcode values, sequencer FSM states and opcode classification
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_EQ  = 4'd4;
  localparam logic [3:0] OP_GT  = 4'd5;
  localparam logic [3:0] OP_LT  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ARITH   = 2'd0,
    CLS_CMP     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR: cls = CLS_ARITH;
      OP_EQ, OP_GT, OP_LT:            cls = CLS_CMP;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous show-ahead FIFO holding packed ALU commands.
// Push is ignored when full and pop is ignored when empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign dout  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds buffered commands to an external combinational ALU from registers, captures
// its result one cycle later, tracks a chaining accumulator and counts illegal ops.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int N_ALU      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [N_ALU-1:0]    cmd_a,
  input  logic [N_ALU-1:0]    cmd_b,
  input  logic                cmd_chain,
  output logic [N_ALU-1:0]    alu_dia,
  output logic [N_ALU-1:0]    alu_dib,
  output logic [3:0]          alu_op,
  input  logic [N_ALU-1:0]    alu_dout,
  input  logic                alu_err,
  input  logic                alu_zero,
  input  logic                alu_of,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N_ALU-1:0]    res_data,
  output logic                res_err,
  output logic                res_zero,
  output logic                res_of,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int ENTRY_W = 4 + 2 * N_ALU + 1;
  localparam logic [ERRCNT_W-1:0] ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  logic [3:0]         ent_op;
  logic [N_ALU-1:0]   ent_a;
  logic [N_ALU-1:0]   ent_b;
  logic               ent_chain;

  state_t             state_reg;
  state_t             state_next;
  logic [N_ALU-1:0]   acc_reg;

  assign cmd_ready = !fifo_full;
  assign fifo_din  = {cmd_op, cmd_a, cmd_b, cmd_chain};
  assign {ent_op, ent_a, ent_b, ent_chain} = fifo_dout;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_HOLD;
      ST_HOLD: begin
        // Hand-off and next pop share a cycle, giving one result every two cycles.
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_EXEC;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign res_valid = (state_reg == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_dia  <= '0;
      alu_dib  <= '0;
      alu_op   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      res_zero <= 1'b0;
      res_of   <= 1'b0;
      acc_reg  <= '0;
      err_cnt  <= '0;
    end else begin
      // Pop only happens after the previous capture, so acc_reg is already current.
      if (fifo_pop) begin
        alu_op  <= ent_op;
        alu_dia <= ent_chain ? acc_reg : ent_a;
        alu_dib <= ent_b;
      end
      if (state_reg == ST_EXEC) begin
        res_data <= '0;
        res_err  <= 1'b0;
        res_zero <= 1'b0;
        res_of   <= 1'b0;
        case (op_class(alu_op))
          CLS_ARITH: begin
            res_data <= alu_dout;
            acc_reg  <= alu_dout;
            res_of   <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) && alu_of;
          end
          CLS_CMP: res_zero <= alu_zero;
          default: begin
            res_data <= '1;
            res_err  <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
          end
        endcase
      end
    end
  end

  // The ALU's own illegal flag is redundant with the opcode decode above.
  logic unused_alu_err;
  assign unused_alu_err = alu_err;

endmodule
